// File: rtl/mlp_sequencer.sv
// Time-multiplexed controller for a 784-30-10 MLP: one shared signed MAC, internal hidden buffer, argmax.
// Define OL_SCORES_EN to expose the output-layer activations on the scores port.
module mlp_sequencer #(
  parameter int unsigned PIXELS     = 784,
  parameter int unsigned RESOLUTION = 8,
  parameter int unsigned HL_NEURONS = 30,
  parameter int unsigned OL_NEURONS = 10,
  parameter int unsigned ACC_W      = 24,
  parameter int unsigned FRAC       = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [3:0]                   digit,
  output logic [9:0]                   pixel_addr,
  input  logic signed [RESOLUTION-1:0] pixel_data,
  output logic [14:0]                  weight_addr,
  input  logic signed [RESOLUTION-1:0] weight_data,
  output logic [5:0]                   bias_addr,
  input  logic signed [RESOLUTION-1:0] bias_data,
  output logic signed [RESOLUTION-1:0] sig_z,
  input  logic signed [RESOLUTION-1:0] sig_a
`ifdef OL_SCORES_EN
  ,
  output logic [OL_NEURONS*RESOLUTION-1:0] scores
`endif
);

  localparam int unsigned PROD_W = 2 * RESOLUTION;
  localparam int unsigned SUM_W  = ACC_W - FRAC + 1;
  localparam int unsigned NW     = $clog2(HL_NEURONS);
  localparam int unsigned OW     = $clog2(OL_NEURONS);

  localparam logic [9:0]              I_HL_LAST    = 10'(PIXELS - 1);
  localparam logic [9:0]              I_OL_LAST    = 10'(HL_NEURONS - 1);
  localparam logic [NW-1:0]           N_HL_LAST    = NW'(HL_NEURONS - 1);
  localparam logic [NW-1:0]           N_OL_LAST    = NW'(OL_NEURONS - 1);
  localparam logic [5:0]              OL_BIAS_BASE = 6'(HL_NEURONS);
  localparam logic signed [SUM_W-1:0] Z_MAX        = SUM_W'((1 << (RESOLUTION - 1)) - 1);
  localparam logic signed [SUM_W-1:0] Z_MIN        = ~Z_MAX;

  typedef enum logic [2:0] {
    S_IDLE, S_HL_MAC, S_HL_DRAIN, S_HL_BIAS, S_OL_MAC, S_OL_DRAIN, S_OL_BIAS, S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [NW-1:0]           n_q, n_d;
  logic [9:0]              i_q, i_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [3:0]              digit_q, digit_d;
  logic [9:0]              pix_q, pix_d;
  logic [14:0]             waddr_q, waddr_d;
  logic [5:0]              baddr_q, baddr_d;
  logic signed [RESOLUTION-1:0] sig_z_q, sig_z_d;
  logic signed [RESOLUTION-1:0] act_q, act_d;
  logic signed [RESOLUTION-1:0] max_q, max_d;
  logic [3:0]              arg_q, arg_d;
  logic signed [RESOLUTION-1:0] hbuf_q [HL_NEURONS];
  logic                    hbuf_we;
  logic                    score_we;

  logic signed [RESOLUTION-1:0] mac_a;
  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_W-1:0]      acc_mac;
  logic signed [SUM_W-1:0]      z_sum;
  logic signed [RESOLUTION-1:0] z_sat;

  // Datapath: operand select, MAC, shift + bias, saturation to the activation range.
  assign mac_a   = (state_q == S_OL_MAC || state_q == S_OL_DRAIN) ? act_q : pixel_data;
  assign prod    = mac_a * weight_data;
  assign acc_mac = acc_q + ACC_W'(prod);
  assign z_sum   = SUM_W'(acc_mac >>> FRAC) + SUM_W'(bias_data);
  assign z_sat   = (z_sum > Z_MAX) ? RESOLUTION'(Z_MAX) :
                   (z_sum < Z_MIN) ? RESOLUTION'(Z_MIN) : RESOLUTION'(z_sum);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    i_d      = i_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    digit_d  = digit_q;
    pix_d    = pix_q;
    waddr_d  = waddr_q;
    baddr_d  = baddr_q;
    sig_z_d  = sig_z_q;
    act_d    = '0;
    max_d    = max_q;
    arg_d    = arg_q;
    hbuf_we  = 1'b0;
    score_we = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HL_MAC;
          n_d     = '0;
          i_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          pix_d   = '0;
          waddr_d = '0;
          baddr_d = '0;
        end
      end
      S_HL_MAC: begin
        // Data for address i arrives one cycle later, so cycle i=0 has nothing to consume.
        if (i_q != '0) acc_d = acc_mac;
        if (i_q == I_HL_LAST) begin
          state_d = S_HL_DRAIN;
        end else begin
          i_d     = i_q + 10'd1;
          pix_d   = pix_q + 10'd1;
          waddr_d = waddr_q + 15'd1;
        end
      end
      S_HL_DRAIN: begin
        acc_d   = acc_mac;
        sig_z_d = z_sat;
        state_d = S_HL_BIAS;
      end
      S_HL_BIAS: begin
        hbuf_we = 1'b1;
        acc_d   = '0;
        i_d     = '0;
        pix_d   = '0;
        waddr_d = waddr_q + 15'd1;
        if (n_q == N_HL_LAST) begin
          state_d = S_OL_MAC;
          n_d     = '0;
          baddr_d = OL_BIAS_BASE;
        end else begin
          state_d = S_HL_MAC;
          n_d     = n_q + NW'(1);
          baddr_d = 6'(n_q) + 6'd1;
        end
      end
      S_OL_MAC: begin
        act_d = hbuf_q[i_q[NW-1:0]];
        if (i_q != '0) acc_d = acc_mac;
        if (i_q == I_OL_LAST) begin
          state_d = S_OL_DRAIN;
        end else begin
          i_d     = i_q + 10'd1;
          waddr_d = waddr_q + 15'd1;
        end
      end
      S_OL_DRAIN: begin
        acc_d   = acc_mac;
        sig_z_d = z_sat;
        state_d = S_OL_BIAS;
      end
      S_OL_BIAS: begin
        score_we = 1'b1;
        acc_d    = '0;
        i_d      = '0;
        // Strictly greater keeps the lowest index on ties.
        if (n_q == '0 || sig_a > max_q) begin
          max_d = sig_a;
          arg_d = 4'(n_q);
        end
        if (n_q == N_OL_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          digit_d = arg_d;
          n_d     = '0;
          waddr_d = '0;
          baddr_d = '0;
        end else begin
          state_d = S_OL_MAC;
          n_d     = n_q + NW'(1);
          waddr_d = waddr_q + 15'd1;
          baddr_d = OL_BIAS_BASE + 6'(n_q) + 6'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      digit_q <= '0;
      pix_q   <= '0;
      waddr_q <= '0;
      baddr_q <= '0;
      sig_z_q <= '0;
      act_q   <= '0;
      max_q   <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      digit_q <= digit_d;
      pix_q   <= pix_d;
      waddr_q <= waddr_d;
      baddr_q <= baddr_d;
      sig_z_q <= sig_z_d;
      act_q   <= act_d;
      max_q   <= max_d;
      arg_q   <= arg_d;
    end
  end

  // Hidden activation buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < HL_NEURONS; k++) hbuf_q[k] <= '0;
    end else if (hbuf_we) begin
      hbuf_q[n_q] <= sig_a;
    end
  end

`ifdef OL_SCORES_EN
  logic signed [RESOLUTION-1:0] scores_q [OL_NEURONS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < OL_NEURONS; k++) scores_q[k] <= '0;
    end else if (score_we) begin
      scores_q[n_q[OW-1:0]] <= sig_a;
    end
  end

  for (genvar k = 0; k < OL_NEURONS; k++) begin : g_scores
    assign scores[k*RESOLUTION +: RESOLUTION] = scores_q[k];
  end
`else
  logic unused_score_we;
  assign unused_score_we = score_we;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign digit       = digit_q;
  assign pixel_addr  = pix_q;
  assign weight_addr = waddr_q;
  assign bias_addr   = baddr_q;
  assign sig_z       = sig_z_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// Directed bench for mlp_sequencer: ROM models, identity sigmoid, hand-computed z/argmax per image set.
module tb_mlp_sequencer;

  localparam int LATENCY  = 23901;
  localparam int HL_BLK   = 786;
  localparam int OL_BLK   = 32;
  localparam int HL_END   = 23580;
  localparam int OL_END   = 23900;
  localparam int MAX_CYC  = 24100;
  localparam int ABORT_AT = 12000;
  localparam int OL_WBASE = 23520;

  logic              clk;
  logic              reset;
  logic              start;
  logic              busy;
  logic              done;
  logic [3:0]        digit;
  logic [9:0]        pixel_addr;
  logic signed [7:0] pixel_data;
  logic [14:0]       weight_addr;
  logic signed [7:0] weight_data;
  logic [5:0]        bias_addr;
  logic signed [7:0] bias_data;
  logic signed [7:0] sig_z;
  logic signed [7:0] sig_a;
`ifdef OL_SCORES_EN
  logic [79:0]       scores;
`endif

  logic signed [7:0] pixel_mem  [1024];
  logic signed [7:0] weight_mem [32768];
  logic signed [7:0] bias_mem   [64];
  int                exp_hz [30];
  int                exp_oz [10];
  int                exp_digit;
  int                n_checks;
  int                n_errors;
  int                lat;

  mlp_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .digit       (digit),
    .pixel_addr  (pixel_addr),
    .pixel_data  (pixel_data),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .bias_addr   (bias_addr),
    .bias_data   (bias_data),
    .sig_z       (sig_z),
    .sig_a       (sig_a)
`ifdef OL_SCORES_EN
    ,
    .scores      (scores)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign sig_a = sig_z;

  always @(posedge clk) begin
    pixel_data  <= pixel_mem[pixel_addr];
    weight_data <= weight_mem[weight_addr];
    bias_data   <= bias_mem[bias_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int widx(input int m, input int j);
    return OL_WBASE + m * 30 + j;
  endfunction

  task automatic clear_all();
    for (int k = 0; k < 1024; k++) pixel_mem[k] = '0;
    for (int k = 0; k < 32768; k++) weight_mem[k] = '0;
    for (int k = 0; k < 64; k++) bias_mem[k] = '0;
    for (int k = 0; k < 30; k++) exp_hz[k] = 0;
    for (int k = 0; k < 10; k++) exp_oz[k] = 0;
  endtask

  // Zero weights: hidden z is its bias, output z is its bias; only class 7 is non-zero.
  task automatic load_a();
    clear_all();
    for (int k = 0; k < 784; k++) pixel_mem[k] = 8'((k % 7) - 3);
    for (int k = 0; k < 30; k++) begin
      bias_mem[k] = 8'(2 * k - 29);
      exp_hz[k]   = 2 * k - 29;
    end
    bias_mem[37] = 8'sd100;
    exp_oz[7]    = 100;
    exp_digit    = 7;
  endtask

  // 784*127 = 99568, >>>4 = 6223 saturates to 127; OL: 127>>>4=7, -127>>>4=-8, 7-10=-3.
  task automatic load_c();
    clear_all();
    for (int k = 0; k < 784; k++) pixel_mem[k] = 8'sd127;
    for (int k = 0; k < OL_WBASE; k++) weight_mem[k] = 8'sd1;
    weight_mem[widx(3, 0)]  = 8'sd1;
    weight_mem[widx(1, 0)]  = -8'sd1;
    weight_mem[widx(9, 29)] = 8'sd1;
    bias_mem[39] = -8'sd10;
    for (int k = 0; k < 30; k++) exp_hz[k] = 127;
    exp_oz[3] = 7;
    exp_oz[1] = -8;
    exp_oz[9] = -3;
    exp_digit = 3;
  endtask

  // Hidden saturates to -128; classes 5 and 6 tie at 10, lower index wins.
  task automatic load_d();
    clear_all();
    for (int k = 0; k < 784; k++) pixel_mem[k] = 8'sd127;
    for (int k = 0; k < OL_WBASE; k++) weight_mem[k] = -8'sd1;
    weight_mem[widx(2, 1)]  = 8'sd1;
    weight_mem[widx(5, 0)]  = -8'sd1;
    weight_mem[widx(6, 29)] = -8'sd1;
    weight_mem[widx(8, 3)]  = 8'sd3;
    bias_mem[30] = -8'sd3;
    bias_mem[35] = 8'sd2;
    bias_mem[36] = 8'sd2;
    for (int k = 0; k < 30; k++) exp_hz[k] = -128;
    exp_oz[0] = -3;
    exp_oz[2] = -8;
    exp_oz[5] = 10;
    exp_oz[6] = 10;
    exp_oz[8] = -24;
    exp_digit = 5;
  endtask

  // Called at a falling edge; this cycle is cycle 0 (start high). Returns the done cycle or -1.
  task automatic run_job(input int p1, input int p2, input int held, input bit chk_held,
                         output int done_cyc);
    bit busy_ok;
    bit held_ok;
    busy_ok  = 1'b1;
    held_ok  = 1'b1;
    done_cyc = -1;
    start    = 1'b1;
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      start = (c == p1 || c == p2);
      if (c <= HL_END && c % HL_BLK == 0)
        chk("hl_sig_z", int'(sig_z), exp_hz[c / HL_BLK - 1]);
      else if (c > HL_END && c <= OL_END && (c - HL_END) % OL_BLK == 0)
        chk("ol_sig_z", int'(sig_z), exp_oz[(c - HL_END) / OL_BLK - 1]);
      if (done) begin
        done_cyc = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (chk_held && int'(digit) != held) held_ok = 1'b0;
    end
    start = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
    chk("busy_during_run", int'(busy_ok), 1);
    if (chk_held) chk("digit_held", int'(held_ok), 1);
  endtask

  task automatic check_result(input int done_cyc);
    chk("latency", done_cyc, LATENCY);
    chk("digit", int'(digit), exp_digit);
    chk("busy_at_done", int'(busy), 0);
`ifdef OL_SCORES_EN
    for (int k = 0; k < 10; k++) chk("scores", int'($signed(scores[k*8 +: 8])), exp_oz[k]);
`endif
  endtask

  task automatic abort_job();
    bit no_done;
    no_done = 1'b1;
    start   = 1'b1;
    for (int c = 1; c <= ABORT_AT; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c % HL_BLK == 0) chk("hl_sig_z_neg", int'(sig_z), exp_hz[c / HL_BLK - 1]);
      if (done) no_done = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_digit", int'(digit), 0);
    chk("abort_sig_z", int'(sig_z), 0);
    chk("abort_waddr", int'(weight_addr), 0);
    repeat (3) begin
      @(negedge clk);
      if (done) no_done = 1'b0;
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("abort_no_done", int'(no_done), 1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    start    = 1'b0;
    load_a();
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_digit", int'(digit), 0);
    chk("rst_paddr", int'(pixel_addr), 0);
    chk("rst_waddr", int'(weight_addr), 0);
    chk("rst_baddr", int'(bias_addr), 0);
    chk("rst_sig_z", int'(sig_z), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Latency run with start re-pulsed while busy.
    run_job(5, 20000, 0, 1'b0, lat);
    check_result(lat);

    // Start during the done cycle is ignored; start in the following idle cycle begins a new run.
    load_c();
    start = 1'b1;
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);
    chk("idle_after_done", int'(busy), 0);
    run_job(-1, -1, 7, 1'b1, lat);
    check_result(lat);
    @(negedge clk);
    chk("done_pulse_width2", int'(done), 0);

    // Reset mid-run, then a fresh full run on the negative image set.
    load_d();
    abort_job();
    run_job(-1, -1, 0, 1'b1, lat);
    check_result(lat);
    @(negedge clk);
    chk("done_pulse_width3", int'(done), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
